// File: rtl/procesador_pkg.sv
// Shared encodings for the data-memory arbiter: read-tracking FSM states and
// read-owner identifiers.
package procesador_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter (cpu vs dbg) with a debug lock override.
// Grants are combinational; only the last-grant pointer is registered.
module rr_arb2 (
    input  logic clk,
    input  logic reset,
    input  logic cpu_req_i,
    input  logic dbg_req_i,
    input  logic lock_i,
    output logic cpu_gnt_o,
    output logic dbg_gnt_o
);
    import procesador_pkg::*;

    owner_e last_q, last_d;

    always_comb begin
        cpu_gnt_o = 1'b0;
        dbg_gnt_o = 1'b0;
        if (reset) begin
            if (lock_i) begin
                dbg_gnt_o = dbg_req_i;
            end else if (cpu_req_i && dbg_req_i) begin
                // Tie goes to whichever side did not win last time.
                if (last_q == OWN_DBG) cpu_gnt_o = 1'b1;
                else                   dbg_gnt_o = 1'b1;
            end else begin
                cpu_gnt_o = cpu_req_i;
                dbg_gnt_o = dbg_req_i;
            end
        end
        last_d = last_q;
        if (cpu_gnt_o)      last_d = OWN_CPU;
        else if (dbg_gnt_o) last_d = OWN_DBG;
    end

    always_ff @(posedge clk) begin
        if (!reset) last_q <= OWN_DBG;
        else        last_q <= last_d;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a cpu port and a debug port onto one single-port data memory and
// steers the one-cycle-late read data back to whichever port issued the read.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    input  logic              dbg_lock,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    import procesador_pkg::*;

    state_e state_q;
    owner_e owner_q;
    logic   cpu_rvalid_q, dbg_rvalid_q;
    logic   rd_gnt;

    rr_arb2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .cpu_req_i (cpu_req),
        .dbg_req_i (dbg_req),
        .lock_i    (dbg_lock),
        .cpu_gnt_o (cpu_gnt),
        .dbg_gnt_o (dbg_gnt)
    );

    always_comb begin
        mem_en    = cpu_gnt | dbg_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dbg_gnt) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
        rd_gnt = mem_en & ~mem_we;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            owner_q      <= OWN_CPU;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
        end else begin
            state_q      <= rd_gnt ? RD_WAIT : IDLE;
            if (rd_gnt) owner_q <= dbg_gnt ? OWN_DBG : OWN_CPU;
            cpu_rvalid_q <= rd_gnt & cpu_gnt;
            dbg_rvalid_q <= rd_gnt & dbg_gnt;
        end
    end

    // Gating with reset drops a read whose return cycle coincides with reset.
    assign cpu_rvalid = reset && cpu_rvalid_q && state_q == RD_WAIT && owner_q == OWN_CPU;
    assign dbg_rvalid = reset && dbg_rvalid_q && state_q == RD_WAIT && owner_q == OWN_DBG;
    assign cpu_rdata  = mem_rdata;
    assign dbg_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized
// run against a transaction-level round-robin/read-return model.
module tb_dmem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
    logic [AW-1:0] cpu_addr, dbg_addr;
    logic [DW-1:0] cpu_wdata, dbg_wdata, mem_rdata;
    logic          cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
    logic [DW-1:0] cpu_rdata, dbg_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;

    int checks = 0;
    int fails  = 0;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .dbg_lock(dbg_lock),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
        dbg_lock = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 0;
        tick();
        reset = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 0;
        cpu_req = 1; dbg_req = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({cpu_gnt, dbg_gnt, mem_en} !== 3'b000) begin
                fails++;
                $display("FAIL reset_gnt: got cpu_gnt=%b dbg_gnt=%b mem_en=%b, need 0 0 0", cpu_gnt, dbg_gnt, mem_en);
            end
            tick();
        end
        checks++;
        if ({cpu_rvalid, dbg_rvalid} !== 2'b00) begin
            fails++;
            $display("FAIL reset_rvalid: got %b%b, need 00", cpu_rvalid, dbg_rvalid);
        end
        reset = 1;
        #1;
        checks++;
        if ({cpu_gnt, dbg_gnt} !== 2'b10) begin
            fails++;
            $display("FAIL reset_first_tie: got cpu_gnt=%b dbg_gnt=%b, need 1 0", cpu_gnt, dbg_gnt);
        end
        tick();
    endtask

    task automatic test_cpu_read();
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        #1;
        checks++;
        if ({cpu_gnt, mem_en, mem_we} !== 3'b110 || mem_addr !== 32'h10) begin
            fails++;
            $display("FAIL cpu_read_gnt: got gnt=%b en=%b we=%b addr=%h, need 1 1 0 00000010", cpu_gnt, mem_en, mem_we, mem_addr);
        end
        tick();
        cpu_req = 0; mem_rdata = 32'hDEADBEEF;
        #1;
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF || dbg_rvalid !== 1'b0) begin
            fails++;
            $display("FAIL cpu_read_data: got rvalid=%b rdata=%h dbg_rvalid=%b, need 1 deadbeef 0", cpu_rvalid, cpu_rdata, dbg_rvalid);
        end
        tick();
        #1;
        checks++;
        if (cpu_rvalid !== 1'b0) begin
            fails++;
            $display("FAIL cpu_read_single: got rvalid=%b in cycle 2, need 0", cpu_rvalid);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_g;
        logic [1:0] exp_rv;
        do_reset();
        cpu_req = 1; cpu_addr = 32'h100; dbg_req = 1; dbg_addr = 32'h200;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin cpu_req = 0; dbg_req = 0; end
            mem_rdata = 32'hA000 + i;
            exp_g  = (i == 4) ? 2'b00 : ((i % 2 == 0) ? 2'b10 : 2'b01);
            exp_rv = (i == 0) ? 2'b00 : (((i - 1) % 2 == 0) ? 2'b10 : 2'b01);
            #1;
            checks++;
            if ({cpu_gnt, dbg_gnt} !== exp_g || {cpu_rvalid, dbg_rvalid} !== exp_rv) begin
                fails++;
                $display("FAIL b2b_cycle%0d: got gnt=%b%b rvalid=%b%b, need gnt=%b rvalid=%b",
                         i, cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, exp_g, exp_rv);
            end
            tick();
        end
    endtask

    task automatic test_lock();
        do_reset();
        cpu_req = 1; dbg_req = 1; dbg_lock = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({cpu_gnt, dbg_gnt} !== 2'b01) begin
                fails++;
                $display("FAIL lock_cycle%0d: got cpu_gnt=%b dbg_gnt=%b, need 0 1", i, cpu_gnt, dbg_gnt);
            end
            tick();
        end
        dbg_lock = 0;
        #1;
        checks++;
        if ({cpu_gnt, dbg_gnt} !== 2'b10) begin
            fails++;
            $display("FAIL lock_release: got cpu_gnt=%b dbg_gnt=%b, need 1 0", cpu_gnt, dbg_gnt);
        end
        tick();
    endtask

    task automatic test_write();
        do_reset();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h8; cpu_wdata = 32'h5;
        #1;
        checks++;
        if ({cpu_gnt, mem_en, mem_we} !== 3'b111 || mem_addr !== 32'h8 || mem_wdata !== 32'h5) begin
            fails++;
            $display("FAIL cpu_write: got gnt=%b en=%b we=%b addr=%h wdata=%h, need 1 1 1 8 5",
                     cpu_gnt, mem_en, mem_we, mem_addr, mem_wdata);
        end
        tick();
        cpu_req = 0; cpu_we = 0;
        #1;
        checks++;
        if (cpu_rvalid !== 1'b0 || dbg_rvalid !== 1'b0) begin
            fails++;
            $display("FAIL write_no_rvalid: got cpu_rvalid=%b dbg_rvalid=%b, need 0 0", cpu_rvalid, dbg_rvalid);
        end
        tick();
    endtask

    task automatic test_reset_discard();
        do_reset();
        dbg_req = 1; dbg_we = 0; dbg_addr = 32'h44;
        #1;
        checks++;
        if (dbg_gnt !== 1'b1) begin
            fails++;
            $display("FAIL discard_gnt: got dbg_gnt=%b, need 1", dbg_gnt);
        end
        tick();
        dbg_req = 0; reset = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) reset = 1;
            #1;
            checks++;
            if (dbg_rvalid !== 1'b0) begin
                fails++;
                $display("FAIL discard_cycle%0d: got dbg_rvalid=%b, need 0", i, dbg_rvalid);
            end
            tick();
        end
    endtask

    // Model: a pending request per port is held until granted; ties alternate
    // away from the last winner; reads return on the owner one cycle later.
    task automatic test_random();
        int last_dbg;   // 1 when dbg won the most recent grant
        int prev_rd;    // -1 none, 0 cpu read last cycle, 1 dbg read last cycle
        logic ec, ed, erc, erd, granted_we;
        logic [AW-1:0] g_addr;
        logic [DW-1:0] g_wdata;
        int lock_left = 0;
        do_reset();
        last_dbg = 1; prev_rd = -1;
        for (int n = 0; n < 400; n++) begin
            if (!cpu_req && $urandom_range(0, 2) != 0) begin
                cpu_req = 1; cpu_we = $urandom_range(0, 1);
                cpu_addr = $urandom; cpu_wdata = $urandom;
            end
            if (!dbg_req && $urandom_range(0, 2) != 0) begin
                dbg_req = 1; dbg_we = $urandom_range(0, 1);
                dbg_addr = $urandom; dbg_wdata = $urandom;
            end
            if (lock_left == 0 && $urandom_range(0, 15) == 0) lock_left = $urandom_range(1, 5);
            dbg_lock = (lock_left != 0);
            if (lock_left != 0) lock_left--;
            reset = ($urandom_range(0, 39) != 0);
            mem_rdata = $urandom;

            ec = 0; ed = 0;
            if (reset) begin
                if (dbg_lock)              ed = dbg_req;
                else if (cpu_req && dbg_req) begin ec = (last_dbg == 1); ed = (last_dbg == 0); end
                else begin ec = cpu_req; ed = dbg_req; end
            end
            erc = reset && prev_rd == 0;
            erd = reset && prev_rd == 1;
            granted_we = ec ? cpu_we : (ed ? dbg_we : 1'b0);
            g_addr     = ec ? cpu_addr : (ed ? dbg_addr : '0);
            g_wdata    = ec ? cpu_wdata : (ed ? dbg_wdata : '0);

            #1;
            checks++;
            if ({cpu_gnt, dbg_gnt, mem_en} !== {ec, ed, ec | ed}) begin
                fails++;
                $display("FAIL rand_gnt n=%0d: got gnt=%b%b en=%b, need gnt=%b%b en=%b",
                         n, cpu_gnt, dbg_gnt, mem_en, ec, ed, ec | ed);
            end
            checks++;
            if (mem_we !== granted_we || mem_addr !== g_addr || mem_wdata !== g_wdata) begin
                fails++;
                $display("FAIL rand_cmd n=%0d: got we=%b addr=%h wdata=%h, need we=%b addr=%h wdata=%h",
                         n, mem_we, mem_addr, mem_wdata, granted_we, g_addr, g_wdata);
            end
            checks++;
            if ({cpu_rvalid, dbg_rvalid} !== {erc, erd} || cpu_rdata !== mem_rdata || dbg_rdata !== mem_rdata) begin
                fails++;
                $display("FAIL rand_rd n=%0d: got rvalid=%b%b rdata=%h/%h, need rvalid=%b%b rdata=%h",
                         n, cpu_rvalid, dbg_rvalid, cpu_rdata, dbg_rdata, erc, erd, mem_rdata);
            end

            if (!reset) begin
                last_dbg = 1; prev_rd = -1;
            end else if (ec) begin
                last_dbg = 0; prev_rd = cpu_we ? -1 : 0;
            end else if (ed) begin
                last_dbg = 1; prev_rd = dbg_we ? -1 : 1;
            end else begin
                prev_rd = -1;
            end
            tick();
            if (ec) cpu_req = 0;
            if (ed) dbg_req = 0;
        end
        idle_inputs();
        reset = 1;
    endtask

    initial begin
        idle_inputs();
        reset = 0;
        tick();
        test_reset();
        test_cpu_read();
        test_back_to_back();
        test_lock();
        test_write();
        test_reset_discard();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: byte-address width of all address ports.
REQ-002 Parameter DATA_W, default 32: data width of all data ports.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port reset, input, 1: synchronous active-low reset, sampled on rising clk.
REQ-005 Ports cpu_req / cpu_we, input, 1 each: processor load/store request; write when cpu_we=1.
REQ-006 Ports cpu_addr (ADDR_W) / cpu_wdata (DATA_W), input: processor access address and store data.
REQ-007 Port cpu_gnt, output, 1: processor request accepted this cycle.
REQ-008 Ports cpu_rvalid (1) / cpu_rdata (DATA_W), output: processor load data valid / data.
REQ-009 Ports dbg_req, dbg_we (1 each), dbg_addr (ADDR_W), dbg_wdata (DATA_W), input: debug/dump port request, same meaning as the cpu_* inputs.
REQ-010 Ports dbg_gnt (1), dbg_rvalid (1), dbg_rdata (DATA_W), output: debug port grant and read return.
REQ-011 Port dbg_lock, input, 1: debug holds exclusive ownership of memory while high.
REQ-012 Ports mem_en (1), mem_we (1), mem_addr (ADDR_W), mem_wdata (DATA_W), output: single-port data memory command.
REQ-013 Port mem_rdata, input, DATA_W: memory read data, valid the cycle after a read command.

Function
REQ-014 Requester holds req, we, addr and wdata stable until its gnt is high in a rising-edge cycle; violation is undefined.
REQ-015 gnt is combinational from req and arbiter state; at most one of cpu_gnt/dbg_gnt high per cycle.
REQ-016 mem_en = cpu_gnt | dbg_gnt; mem_we, mem_addr and mem_wdata are muxed from the granted port; all are 0 when no grant.
REQ-017 Only one requester: granted the same cycle (zero-cycle grant latency).
REQ-018 Both requesting, dbg_lock=0: round-robin; grant goes to the port not granted last; after reset the cpu wins the first tie.
REQ-019 dbg_lock=1: cpu_gnt forced 0; dbg granted whenever dbg_req=1; last-grant pointer still updates.
REQ-020 Write: complete at grant; no rvalid generated.
REQ-021 Read: owner's rvalid is high exactly one cycle after grant; rdata = mem_rdata in that cycle; the other port's rvalid is 0.
REQ-022 FSM states IDLE and RD_WAIT: a read grant enters RD_WAIT; RD_WAIT with a new read grant stays in RD_WAIT; otherwise returns to IDLE.
REQ-023 Back-to-back: a new grant may issue in the RD_WAIT cycle, so one access per cycle is sustained.
REQ-024 cpu_rdata and dbg_rdata are both driven by mem_rdata; only rvalid qualifies them.
REQ-025 Registered state: FSM state, read owner (1 bit), last-grant pointer (1 bit), rvalid flags.

Reset
REQ-026 While reset=0 at a rising edge: state=IDLE, owner=cpu, last-grant pointer=dbg, cpu_rvalid=0, dbg_rvalid=0.
REQ-027 While reset=0 all gnt outputs and mem_en are 0, regardless of requests.
REQ-028 Reset asserted in the cycle after a read grant discards that read; no rvalid is generated after reset releases.

Structure
REQ-029 The shared package procesador_pkg holds the FSM state encoding (IDLE, RD_WAIT) and the owner encoding (OWN_CPU=0, OWN_DBG=1).
REQ-030 One sub-module, rr_arb2, implements the two-input round-robin grant with lock override; the read-tracking FSM and muxes stay in dmem_arbiter.

Verification
REQ-031 The bench covers: cpu read of addr 0x10 with mem_rdata=0xDEADBEEF next cycle, gives cpu_gnt in cycle 0 and cpu_rvalid=1 with cpu_rdata=0xDEADBEEF in cycle 1.
REQ-032 The bench covers: cpu and dbg reads held together for 4 cycles after reset, giving grants in the order cpu, dbg, cpu, dbg with rvalid following each by one cycle.
REQ-033 The bench covers: dbg_lock=1 with both ports requesting, giving cpu_gnt=0 throughout and dbg granted every cycle; lock drops, then the cpu is granted in the next cycle.
REQ-034 The bench covers: cpu write 0x5 to 0x8, giving mem_we=1, mem_addr=0x8, mem_wdata=0x5 in the grant cycle and no cpu_rvalid.
REQ-035 The bench covers: reset=0 asserted the cycle after a dbg read grant, giving dbg_rvalid=0 in every cycle through reset release.
REQ-036 The bench covers: reset=0 with both reqs high, giving both gnt=0 and mem_en=0; after release with both reqs high, cpu_gnt=1 first.
